// File: rtl/ppa_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ppa_sub_pipe
// Description : Three-stage pipelined Kogge-Stone subtractor (a + ~b + 1)
//               with valid/ready handshakes on both sides.
// Revision    : 1.0
// ============================================================================
module ppa_sub_pipe #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int c_lvls    = $clog2(N);
    localparam int c_s2_lvls = (c_lvls + 1) / 2;
    localparam int c_s3_lvls = c_lvls - c_s2_lvls;

    logic r_v1, r_v2, r_v3;
    logic w_en1, w_en2, w_en3;

    assign w_en3     = !r_v3 || out_ready;
    assign w_en2     = !r_v2 || w_en3;
    assign w_en1     = !r_v1 || w_en2;
    assign in_ready  = w_en1;
    assign out_valid = r_v3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_en1) r_v1 <= in_valid;
            if (w_en2) r_v2 <= r_v1;
            if (w_en3) r_v3 <= r_v2;
        end
    end

    // Stage 1: per-bit propagate/generate with the carry-in of 1 folded into bit 0.
    logic [N-1:0] w_p0, w_g0;
    logic [N-1:0] r_p1, r_g1;

    assign w_p0 = a ^ ~b;
    assign w_g0 = a & ~b;

    always_ff @(posedge clk) begin
        if (w_en1 && in_valid) begin
            r_p1 <= w_p0;
            r_g1 <= {w_g0[N-1:1], w_g0[0] | w_p0[0]};
        end
    end

    // Stage 2: lower prefix levels.
    logic [N-1:0] w_g2 [0:c_s2_lvls];
    logic [N-1:0] w_p2 [0:c_s2_lvls];

    assign w_g2[0] = r_g1;
    assign w_p2[0] = r_p1;

    for (genvar k = 0; k < c_s2_lvls; k++) begin : g_s2_lvl
        localparam int c_d = 1 << k;
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= c_d) begin : g_cell
                assign w_g2[k+1][i] = w_g2[k][i] | (w_g2[k][i-c_d] & w_p2[k][i]);
                assign w_p2[k+1][i] = w_p2[k][i] & w_p2[k][i-c_d];
            end else begin : g_pass
                assign w_g2[k+1][i] = w_g2[k][i];
                assign w_p2[k+1][i] = w_p2[k][i];
            end
        end
    end

    logic [N-1:0] r_g2, r_p2, r_pb2;

    always_ff @(posedge clk) begin
        if (w_en2 && r_v1) begin
            r_g2  <= w_g2[c_s2_lvls];
            r_p2  <= w_p2[c_s2_lvls];
            r_pb2 <= r_p1;
        end
    end

    // Stage 3: remaining prefix levels; the last level needs no group propagate.
    logic [N-1:0] w_g3 [0:c_s3_lvls];
    logic [N-1:0] w_p3 [0:c_s3_lvls-1];

    assign w_g3[0] = r_g2;
    assign w_p3[0] = r_p2;

    for (genvar j = 0; j < c_s3_lvls; j++) begin : g_s3_lvl
        localparam int c_d = 1 << (c_s2_lvls + j);
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= c_d) begin : g_cell
                assign w_g3[j+1][i] = w_g3[j][i] | (w_g3[j][i-c_d] & w_p3[j][i]);
                if (j + 1 < c_s3_lvls) begin : g_p
                    assign w_p3[j+1][i] = w_p3[j][i] & w_p3[j][i-c_d];
                end
            end else begin : g_pass
                assign w_g3[j+1][i] = w_g3[j][i];
                if (j + 1 < c_s3_lvls) begin : g_p
                    assign w_p3[j+1][i] = w_p3[j][i];
                end
            end
        end
    end

    logic [N-1:0] w_diff;
    logic         w_borrow;
    logic [N-1:0] r_diff;
    logic         r_borrow;

    assign w_diff   = {r_pb2[N-1:1] ^ w_g3[c_s3_lvls][N-2:0], ~r_pb2[0]};
    assign w_borrow = ~w_g3[c_s3_lvls][N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_en3 && r_v2) begin
            r_diff   <= w_diff;
            r_borrow <= w_borrow;
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_ppa_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppa_sub_pipe
// Description : Scoreboard bench for ppa_sub_pipe against (a-b) mod 2^N, a<b.
// Revision    : 1.0
// ============================================================================
module tb_ppa_sub_pipe;

    localparam int N     = 16;
    localparam int TOTAL = 10000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;

    always #5 clk = ~clk;

    ppa_sub_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    typedef struct {
        logic [N-1:0] d;
        logic         bw;
        int           c;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_out  = 0;
    bit   strict_lat = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void push_exp(input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.bw = (x < y);
        e.c  = cyc;
        sbq.push_back(e);
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    // Monitor: pops the scoreboard on every output transfer.
    bit           prev_hold = 1'b0;
    logic [N-1:0] prev_d;
    logic         prev_b;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_diff", 64'(diff), 64'(prev_d));
                check("stall_borrow", 64'(borrow), 64'(prev_b));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("diff", 64'(diff), 64'(e.d));
                    check("borrow", 64'(borrow), 64'(e.bw));
                    if (strict_lat) check("latency", 64'(cyc - e.c), 64'd3);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_d    = diff;
            prev_b    = borrow;
        end
    end

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        a = x;
        b = y;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(x, y);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 100) begin
                check("send_timeout", 64'd1, 64'd0);
                done = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc;
        int sent;
        int guard;
        bit took;
        int mode;

        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h1111;
        b         = 16'h2222;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_borrow", 64'(borrow), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed values, back to back with strict latency.
        strict_lat = 1'b1;
        base = n_out;
        send(16'h1234, 16'h0234);
        send(16'h0000, 16'h0001);
        send(16'h8000, 16'hFFFF);
        send(16'hA5A5, 16'hA5A5);
        for (int i = 0; i < 8; i++) send(N'($urandom), N'($urandom));
        in_valid = 1'b0;
        drain();
        check("b2b_count", 64'(n_out - base), 64'd12);
        strict_lat = 1'b0;

        // Backpressure: fill with the output stalled.
        base = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = N'($urandom);
        b = N'($urandom);
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            took = 1'b0;
            if (in_ready) begin
                push_exp(a, b);
                acc++;
                took = 1'b1;
            end
            @(posedge clk); #1;
            if (took) begin
                a = N'($urandom);
                b = N'($urandom);
            end
        end
        check("bp_accepts", 64'(acc), 64'd3);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("bp_count", 64'(n_out - base), 64'd3);

        // Reset with three operations in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(N'($urandom), N'($urandom));
        in_valid = 1'b0;
        rst = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Random traffic.
        sent  = 0;
        guard = 0;
        while ((sent < TOTAL || sbq.size() != 0) && guard < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < TOTAL && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                mode = $urandom_range(0, 7);
                a = N'($urandom);
                b = N'($urandom);
                if (mode == 0) b = a;
                else if (mode == 1) a = '0;
                else if (mode == 2) b = '1;
            end
            @(negedge clk);
            took = 1'b0;
            if (in_valid && in_ready) begin
                push_exp(a, b);
                sent++;
                took = 1'b1;
            end
            @(posedge clk); #1;
            if (took) in_valid = 1'b0;
            guard++;
        end
        check("rand_sent", 64'(sent), 64'(TOTAL));
        check("rand_left", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
